// File: rtl/decode_queue.sv
// Buffered MIPS instruction decoder: fetch FIFO feeding a registered decode stage.
// Optional back-pressure counter enabled by defining DECODE_QUEUE_STALL_CNT_EN.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       instr_valid_i,
  input  logic [31:0]                instr_i,
  input  logic [PC_W-1:0]            pc_i,
  output logic                       instr_ready_o,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [4:0]                 rs_o,
  output logic [4:0]                 rt_o,
  output logic [4:0]                 rd_o,
  output logic [5:0]                 op_o,
  output logic [5:0]                 funct_o,
  output logic [4:0]                 shamt_o,
  output logic [25:0]                target_o,
  output logic [31:0]                imm_o,
  output logic                       is_r_type_o,
  output logic                       is_i_type_o,
  output logic                       is_j_type_o,
  output logic                       use_link_reg_o,
  output logic [4:0]                 dest_reg_o,
  output logic [PC_W-1:0]            pc_o,
  output logic [PC_W-1:0]            branch_target_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [31:0]                stall_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      shamt;
    logic [25:0]     target;
    logic [31:0]     imm;
    logic            is_r;
    logic            is_i;
    logic            is_j;
    logic            link;
    logic [4:0]      dest;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] bt;
  } dec_t;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q    [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            dec_valid_q, dec_valid_d;
  dec_t            dec_q, dec_d, head;
  logic            push, pop;
  logic [31:0]     hi;
  logic [PC_W-1:0] hpc, off;
  logic            regimm_link;

  assign instr_ready_o = (count_q != CW'(DEPTH));
  assign push = instr_valid_i && instr_ready_o;
  assign pop  = (count_q != '0) && (!dec_valid_q || dec_ready_i);

  always_comb begin
    hi  = instr_mem_q[rd_ptr_q];
    hpc = pc_mem_q[rd_ptr_q];
    head        = '0;
    head.rs     = hi[25:21];
    head.rt     = hi[20:16];
    head.rd     = hi[15:11];
    head.op     = hi[31:26];
    head.funct  = hi[5:0];
    head.shamt  = hi[10:6];
    head.target = hi[25:0];
    head.is_r   = (head.op == 6'h00);
    head.is_j   = (head.op == 6'h02) || (head.op == 6'h03);
    head.is_i   = !head.is_r && !head.is_j;
    if (head.op inside {6'h0C, 6'h0D, 6'h0E}) head.imm = {16'h0000, hi[15:0]};
    else                                      head.imm = {{16{hi[15]}}, hi[15:0]};
    regimm_link = (head.op == 6'h01) && ((head.rt == 5'h10) || (head.rt == 5'h11));
    head.link   = regimm_link || (head.is_r && head.funct == 6'h09) || (head.op == 6'h03);
    if (head.is_r)                             head.dest = head.rd;
    else if (head.op == 6'h03 || regimm_link)  head.dest = 5'd31;
    else if (head.op == 6'h02)                 head.dest = 5'd0;
    else                                       head.dest = head.rt;
    head.pc = hpc;
    // Branch offset is always the sign-extended immediate, independent of op.
    off     = {{(PC_W-16){hi[15]}}, hi[15:0]};
    head.bt = hpc + PC_W'(4) + (off << 2);
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    dec_valid_d = dec_valid_q;
    dec_d       = dec_q;
    if (flush_i) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      dec_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        dec_valid_d = 1'b1;
        dec_d       = head;
      end else if (dec_valid_q && dec_ready_i) begin
        dec_valid_d = 1'b0;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      dec_q       <= dec_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      instr_mem_q[wr_ptr_q] <= instr_i;
      pc_mem_q[wr_ptr_q]    <= pc_i;
    end
  end

`ifdef DECODE_QUEUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  always_comb stall_cnt_d = stall_cnt_q + 32'(dec_valid_q && !dec_ready_i);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign count_o         = count_q;
  assign dec_valid_o     = dec_valid_q;
  assign rs_o            = dec_q.rs;
  assign rt_o            = dec_q.rt;
  assign rd_o            = dec_q.rd;
  assign op_o            = dec_q.op;
  assign funct_o         = dec_q.funct;
  assign shamt_o         = dec_q.shamt;
  assign target_o        = dec_q.target;
  assign imm_o           = dec_q.imm;
  assign is_r_type_o     = dec_q.is_r;
  assign is_i_type_o     = dec_q.is_i;
  assign is_j_type_o     = dec_q.is_j;
  assign use_link_reg_o  = dec_q.link;
  assign dest_reg_o      = dec_q.dest;
  assign pc_o            = dec_q.pc;
  assign branch_target_o = dec_q.bt;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, pipelined successor of the combinational MIPS instruction decoder.
- Fetch pushes {instruction, PC} into a DEPTH-entry FIFO.
- The FIFO head is decoded combinationally and captured in an output register with a valid/ready handshake toward issue/execute.
- Adds automatic sign/zero-extension selection, destination-register resolution, branch-target arithmetic and flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PC_W, 32, width of PC and branch-target paths.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous reset, active-low.
- flush_i  in  1  synchronous flush of FIFO and output register.
- instr_valid_i  in  1  fetch presents an instruction.
- instr_i  in  32  instruction word.
- pc_i  in  PC_W  PC of instr_i.
- instr_ready_o  out  1  FIFO can accept.
- dec_valid_o  out  1  decoded output register valid.
- dec_ready_i  in  1  consumer accepts decoded entry.
- rs_o, rt_o, rd_o  out  5 each  register fields [25:21], [20:16], [15:11].
- op_o  out  6  [31:26].
- funct_o  out  6  [5:0].
- shamt_o  out  5  [10:6].
- target_o  out  26  [25:0].
- imm_o  out  32  extended immediate.
- is_r_type_o, is_i_type_o, is_j_type_o  out  1 each  instruction class.
- use_link_reg_o  out  1  instruction writes the link register.
- dest_reg_o  out  5  resolved write-destination register.
- pc_o  out  PC_W  PC of the decoded instruction.
- branch_target_o  out  PC_W  pc + 4 + (sign-extended imm << 2).
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output register.
- stall_cnt_o  out  32  back-pressure cycle count (see Optional Feature).

Behaviour:
- Reset (rst_n_i low, asynchronous): pointers = 0, count_o = 0, dec_valid_o = 0, all registered outputs = 0.
  - instr_ready_o = 1 while rst_n_i is high and the FIFO is empty.
- Push: occurs on instr_valid_i && instr_ready_o.
  - instr_ready_o = (count_o != DEPTH), combinational from count only; no pass-through when full.
- Pop / load: when the FIFO is non-empty and (!dec_valid_o || dec_ready_i), the head is decoded and loaded into the output register.
  - The pop and the load happen on the same edge.
- Drain: dec_valid_o && dec_ready_i with an empty FIFO clears dec_valid_o.
- Hold: dec_valid_o && !dec_ready_i holds every output stable.
- Latency: an entry accepted at edge E into an empty queue shows dec_valid_o = 1 after edge E+1.
- Occupancy updates:
  - simultaneous push and pop leaves count unchanged;
  - push only: +1;
  - pop only: -1.
- Pointers wrap modulo DEPTH.
- Decode rules:
  - Field slicing: bit ranges as listed under Ports.
  - R-type: op == 0.
  - J-type: op == 0x02 or 0x03.
  - I-type: neither R-type nor J-type.
  - Immediate: zero-extended for op 0x0C/0x0D/0x0E (ANDI/ORI/XORI); sign-extended otherwise.
  - use_link_reg_o = 1 for any of:
    - op 0x01 with rt 0x10 or 0x11 (BLTZAL/BGEZAL);
    - R-type with funct 0x09 (JALR);
    - op 0x03 (JAL).
  - dest_reg_o:
    - R-type: rd, which also covers JALR;
    - JAL, BLTZAL, BGEZAL: 31;
    - other I-type: rt;
    - J (op 0x02): 0.
  - branch_target_o always uses the sign-extended immediate, regardless of op.
  - branch_target_o arithmetic is modulo 2^PC_W.
- Flush (flush_i high at an edge):
  - read pointer, write pointer and count reset to 0; dec_valid_o cleared;
  - a push in the same cycle is dropped;
  - a dec_ready_i handshake in the same cycle completes (entry consumed) and is not re-presented.
  - Flush has priority over push/pop.
- Reset asserted mid-operation: all state is discarded immediately, without waiting for a clock.

Optional Feature:
- Macro DECODE_QUEUE_STALL_CNT_EN.
- Defined: stall_cnt_o is a 32-bit counter.
  - Increments each cycle dec_valid_o && !dec_ready_i.
  - Wraps at 2^32-1 -> 0.
  - Cleared by reset only; flush does not clear it.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset mid-stream with 2 entries queued -> immediately count_o = 0, dec_valid_o = 0, instr_ready_o = 1.
- Push ADDI 0x2008FFFF at pc 0x100, dec_ready_i = 1 -> after two edges:
  - dec_valid_o = 1;
  - imm_o = 0xFFFFFFFF;
  - dest_reg_o = 8;
  - is_i_type_o = 1;
  - branch_target_o = 0x100.
- Push ORI 0x3508FFFF -> imm_o = 0x0000FFFF. Push JAL 0x0C000010 -> use_link_reg_o = 1, dest_reg_o = 31, is_j_type_o = 1.
- Hold dec_ready_i = 0, push 5 instructions (DEPTH = 4) -> 1 in output register, count_o = 4, instr_ready_o = 0.
  - Release dec_ready_i -> in-order delivery, no loss or duplication.
- Full queue, flush_i with instr_valid_i = 1 -> count_o = 0, dec_valid_o = 0, pushed word absent.
- With macro defined, 7 back-pressured cycles -> stall_cnt_o = 7; without macro -> stall_cnt_o stays 0.
